vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//   Owns the single read/write port of the 160x120x8 framebuffer RAM and shares it between the pixel fetch
//   and NREQ game-logic requesters. It is driven by the horizontal and vertical counters of the VGA timing generator.
//   The framebuffer is scaled 4x to 640x480, so the pixel path needs the port only on every 4th active cycle.
//   All other cycles, including blanking, go to the requesters round-robin. It also emits a per-frame vblank tick.
// PARAMETERS
//   H_ACTIVE  640    visible pixels per line
//   V_ACTIVE  480    visible lines per frame
//   FB_W      160    framebuffer width in words (H_ACTIVE/4)
//   ADDR_W    15     framebuffer address width (19200 words)
//   NREQ      3      number of requesters (2..4)
// PORTS
//   clk        in   1            pixel clock (25 MHz)
//   rst        in   1            reset, asynchronous, active-low
//   hcounter   in   10           horizontal position from the timing generator
//   vcounter   in   10           vertical position from the timing generator
//   req        in   NREQ         access request, one bit per requester
//   req_we     in   NREQ         1 = write, 0 = read, per requester
//   req_addr   in   NREQ*ADDR_W  packed address; requester i is in [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NREQ*8       packed write data; requester i is in [i*8 +: 8]
//   gnt        out  NREQ         one-hot grant, combinational, only in the slot where the access is issued
//   rvalid     out  NREQ         one-cycle pulse, one cycle after a granted read
//   rdata      out  8            read data, qualified by rvalid
//   mem_addr   out  ADDR_W       RAM address (synchronous RAM, 1-cycle read latency)
//   mem_we     out  1            RAM write enable
//   mem_wdata  out  8            RAM write data
//   mem_rdata  in   8            RAM read data
//   pix_valid  out  1            pix_data is a visible pixel
//   pix_data   out  8            pixel colour, 2 cycles behind hcounter
//   frame_tick out  1            one-cycle pulse at the start of vblank
// BEHAVIOUR
// - Reset (rst=0, asynchronous): gnt, rvalid, rdata, pix_valid, pix_data and frame_tick are all 0.
//   - Round-robin pointer returns to 0.
//   - mem_we=0 while in reset.
//   - Reset mid-frame abandons any in-flight access; no rvalid is produced for it.
// - Active region: hcounter<H_ACTIVE && vcounter<V_ACTIVE.
// - Pixel slot: active && hcounter[1:0]==0.
//   - mem_addr = (vcounter>>2)*FB_W + (hcounter>>2), computed in ADDR_W bits as (r<<7)+(r<<5)+c.
//   - mem_we=0, and gnt is all 0.
// - Request slot: every cycle that is not a pixel slot. This includes all of hblank and vblank.
//   - Grant goes to the first asserted req[i], searching from the pointer p upward with wrap-around.
//   - mem_addr, mem_we and mem_wdata carry requester i's fields, and gnt[i]=1.
//   - After the grant, p becomes (i+1) mod NREQ. p holds when nothing is granted.
//   - With no request: mem_we=0 and mem_addr holds its previous value.
// - Requester handshake:
//   - The requester holds req and its fields stable until it sees gnt.
//   - It may drop req or issue a new access in the cycle after gnt.
//   - req must not depend combinationally on gnt.
//   - A request raised in a pixel slot waits for the next request slot.
// - Reads: rvalid[i]=1 and rdata=mem_rdata in the cycle after the grant. Writes produce no rvalid.
// - Pixel path:
//   - A fetch issued when hcounter=h is registered into pix_data at the end of cycle h+1.
//   - pix_data is visible from h+2 and held for 4 cycles.
//   - pix_valid is the active flag delayed by 2 cycles. When pix_valid=0, pix_data=0.
// - Addresses are not range-checked; requester addresses at or above 19200 pass through unchanged.
// - frame_tick is registered: it is 1 for the one cycle after hcounter==0 && vcounter==V_ACTIVE.
// - Last pixel slot on a line is h=636. Cycles h=637..799 are all request slots.
// TESTING
// - Reset: drive rst=0 at h=100,v=50 with req=3'b111 -> all outputs 0 immediately.
//   After release the first gnt comes at the next non-pixel slot and goes to requester 0.
// - Pixel fetch: h=0,v=0 -> mem_addr=0, we=0. h=4,v=4 -> mem_addr=161.
//   With RAM[0]=0x3C, pix_data=0x3C and pix_valid=1 at h=2..5.
// - Single read: req[1]=1 with addr 0x100 raised at h=0,v=10 -> gnt[1] at h=1; rvalid[1] and rdata=RAM[0x100] at h=2.
// - Contention: req=3'b111 held across an active line -> grants go 0,1,2,0,... and no gnt ever occurs when h%4==0.
// - Write-then-display: requester 2 writes 0xA5 to addr 5 in vblank -> next frame pix_data=0xA5 at h=22..25, v=0.
// - frame_tick: run 2 frames -> exactly 2 pulses, each one cycle after h=0,v=480.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Purpose: owns the single framebuffer RAM port; 4x-scaled pixel fetch takes every 4th active cycle, NREQ requesters share the rest round-robin.
// Latency: gnt/mem_* combinational in the issue slot; rvalid/rdata one cycle after a granted read; pix_data two cycles behind hcounter.
// Backpressure: pixel slots always win; a requester holds req and its fields until it sees gnt.
module vga_fb_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int FB_W     = 160,
   parameter int ADDR_W   = 15,
   parameter int NREQ     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [9:0]             hcounter,
   input  logic [9:0]             vcounter,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*8-1:0]      req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [7:0]             rdata,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_we,
   output logic [7:0]             mem_wdata,
   input  logic [7:0]             mem_rdata,
   output logic                   pix_valid,
   output logic [7:0]             pix_data,
   output logic                   frame_tick
);

   localparam int PW = $clog2(NREQ);

   logic              active;
   logic              pix_slot;
   logic [7:0]        row;
   logic [7:0]        col;
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] addr_q;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     sel;
   logic              found;
   logic              act_d1;
   logic              act_d2;
   logic              fetch_d1;
   logic [7:0]        pix_q;
   logic [NREQ-1:0]   rd_q;
   logic              tick_q;

   assign active   = (hcounter < 10'(H_ACTIVE)) && (vcounter < 10'(V_ACTIVE));
   assign pix_slot = active && (hcounter[1:0] == 2'b00);

   // Framebuffer word address of the 4x4 block under the beam: row*160 + col, row*160 built as (row<<7)+(row<<5)
   assign row      = vcounter[9:2];
   assign col      = hcounter[9:2];
   assign pix_addr = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);

   // Round-robin search: first asserted request at or above the pointer, wrapping at NREQ
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   // Port mux: pixel fetch in pixel slots, otherwise the round-robin winner; idle cycles keep the last address
   always_comb begin
      gnt       = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_addr  = addr_q;
      if (pix_slot) begin
         mem_addr = pix_addr;
      end else if (found && rst) begin
         gnt[sel]  = 1'b1;
         mem_addr  = req_addr[sel*ADDR_W +: ADDR_W];
         mem_we    = req_we[sel];
         mem_wdata = req_wdata[sel*8 +: 8];
      end
   end

   // Arbiter pointer, address hold, read-return strobe, pixel pipeline and vblank tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= '0;
         addr_q   <= '0;
         rd_q     <= '0;
         fetch_d1 <= 1'b0;
         pix_q    <= '0;
         act_d1   <= 1'b0;
         act_d2   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         addr_q <= mem_addr;
         if (|gnt) begin
            ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
         end
         rd_q     <= gnt & ~req_we;
         // RAM data for a fetch issued at h arrives during h+1 and is captured at its end
         fetch_d1 <= pix_slot;
         if (fetch_d1) begin
            pix_q <= mem_rdata;
         end
         act_d1 <= active;
         act_d2 <= act_d1;
         tick_q <= (hcounter == 10'd0) && (vcounter == 10'(V_ACTIVE));
      end
   end

   assign rvalid     = rd_q;
   assign rdata      = (|rd_q) ? mem_rdata : 8'h00;
   assign pix_valid  = act_d2;
   assign pix_data   = act_d2 ? pix_q : 8'h00;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: drives the beam position directly, models the RAM,
// and checks grants, read returns, pixel output and vblank ticks through queues.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hcounter, vcounter;
   logic [2:0]  req, req_we;
   logic [44:0] req_addr;
   logic [23:0] req_wdata;
   logic [2:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        frame_tick;

   typedef struct {logic [2:0] g; logic [14:0] a; logic we; logic [7:0] d;} gnt_t;
   typedef struct {logic [2:0] v; logic [7:0] d;} rd_t;

   gnt_t        exp_g[$];
   rd_t         exp_r[$];
   logic [14:0] exp_f[$];
   logic [7:0]  exp_p[$];
   logic [19:0] exp_t[$];

   logic [7:0]  mem    [0:32767];
   logic [7:0]  shadow [0:32767];
   logic [2:0]  rq, rwe, sticky;
   logic [14:0] raddr [3];
   logic [7:0]  rwd   [3];
   int          ep;
   logic [7:0]  grp_val;
   int          checks, failures, tick_cnt;
   gnt_t        mg;
   rd_t         mr;
   logic [14:0] mf;
   logic [7:0]  mp;
   logic [19:0] mt;

   always #5 clk = ~clk;

   vga_fb_arbiter #(.H_ACTIVE(640), .V_ACTIVE(480), .FB_W(160), .ADDR_W(15), .NREQ(3)) dut (
      .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pix_valid(pix_valid), .pix_data(pix_data), .frame_tick(frame_tick)
   );

   // Synchronous RAM, one cycle read latency
   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_gnt"},        gnt,        0);
      chk({tag, "_rvalid"},     rvalid,     0);
      chk({tag, "_rdata"},      rdata,      0);
      chk({tag, "_pix_valid"},  pix_valid,  0);
      chk({tag, "_pix_data"},   pix_data,   0);
      chk({tag, "_frame_tick"}, frame_tick, 0);
      chk({tag, "_mem_we"},     mem_we,     0);
   endtask

   task automatic drive();
      req       = rq;
      req_we    = rwe;
      req_addr  = {raddr[2], raddr[1], raddr[0]};
      req_wdata = {rwd[2], rwd[1], rwd[0]};
   endtask

   // One beam position: apply inputs, push what the DUT should present, advance a cycle
   task automatic issue(input int h, input int v);
      logic act;
      logic found;
      int   k;
      int   pa;
      found = 1'b0;
      k     = 0;
      hcounter = 10'(h);
      vcounter = 10'(v);
      drive();
      act = (h < 640) && (v < 480);
      if (rst) begin
         if (act && (h % 4 == 0)) begin
            pa = (v / 4) * 160 + h / 4;
            exp_f.push_back(15'(pa));
            grp_val = shadow[pa];
         end else begin
            for (int j = 0; j < 3; j++) begin
               if (!found && rq[(ep + j) % 3]) begin
                  found = 1'b1;
                  k     = (ep + j) % 3;
               end
            end
            if (found) begin
               exp_g.push_back('{g: 3'(1 << k), a: raddr[k], we: rwe[k], d: rwd[k]});
               if (rwe[k]) shadow[raddr[k]] = rwd[k];
               else        exp_r.push_back('{v: 3'(1 << k), d: shadow[raddr[k]]});
               ep = (k + 1) % 3;
            end
         end
         if (act) exp_p.push_back(grp_val);
         if (h == 0 && v == 480) exp_t.push_back({10'd480, 10'd1});
      end
      @(posedge clk);
      #1;
      if (found && !sticky[k]) rq[k] = 1'b0;
   endtask

   // Monitor: pops and compares whenever the DUT presents something
   always @(negedge clk) begin
      if (gnt != 3'b000) begin
         if (exp_g.size() == 0) unexp("gnt_extra", {hcounter, 3'b000, gnt});
         else begin
            mg = exp_g.pop_front();
            chk("gnt", gnt, mg.g);
            chk("gnt_addr", mem_addr, mg.a);
            chk("gnt_we", mem_we, mg.we);
            if (mg.we) chk("gnt_wdata", mem_wdata, mg.d);
         end
      end
      if (rvalid != 3'b000) begin
         if (exp_r.size() == 0) unexp("rvalid_extra", rvalid);
         else begin
            mr = exp_r.pop_front();
            chk("rvalid", rvalid, mr.v);
            chk("rdata", rdata, mr.d);
         end
      end
      if (rst === 1'b1 && hcounter < 10'd640 && vcounter < 10'd480 && hcounter[1:0] == 2'b00) begin
         if (exp_f.size() == 0) unexp("fetch_extra", mem_addr);
         else begin
            mf = exp_f.pop_front();
            chk("fetch_addr", mem_addr, mf);
            chk("fetch_we", mem_we, 0);
            chk("pix_slot_gnt", gnt, 0);
         end
      end
      if (pix_valid === 1'b1) begin
         if (exp_p.size() == 0) unexp("pix_extra", {vcounter, hcounter});
         else begin
            mp = exp_p.pop_front();
            chk("pix_data", pix_data, mp);
         end
      end else begin
         chk("pix_idle_zero", pix_data, 0);
      end
      if (frame_tick === 1'b1) begin
         tick_cnt++;
         if (exp_t.size() == 0) unexp("tick_extra", {vcounter, hcounter});
         else begin
            mt = exp_t.pop_front();
            chk("tick_pos", {vcounter, hcounter}, mt);
         end
      end
   end

   initial begin
      for (int a = 0; a < 32768; a++) begin
         mem[a]    = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
         shadow[a] = mem[a];
      end
      mem[0]    = 8'h3C;
      shadow[0] = 8'h3C;
      checks = 0; failures = 0; tick_cnt = 0; ep = 0; grp_val = 8'h00;
      rst = 1'b0; hcounter = '0; vcounter = '0;
      rq = '0; rwe = '0; sticky = '0;
      for (int i = 0; i < 3; i++) begin
         raddr[i] = '0;
         rwd[i]   = '0;
      end
      drive();
      #2;
      chk_reset("por");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Pixel fetch: RAM[0]=3C shown at h=2..5 v=0; block (1,1) read from 161
      for (int h = 0; h < 12; h++) issue(h, 0);
      for (int h = 0; h < 12; h++) issue(h, 4);

      // Single read raised in a pixel slot: granted at h=1, data at h=2
      raddr[1] = 15'h100;
      rq = 3'b010;
      for (int h = 0; h < 8; h++) issue(h, 10);

      // Reset mid-line with all requesters pending
      for (int h = 92; h < 100; h++) issue(h, 50);
      raddr[0] = 15'h0040;
      raddr[2] = 15'h7FFF;
      rq = 3'b111;
      drive();
      rst = 1'b0;
      exp_p.delete();
      grp_val = 8'h00;
      ep = 0;
      #1;
      chk_reset("mid");
      issue(100, 50);
      issue(101, 50);
      issue(102, 50);
      rst = 1'b1;
      for (int h = 103; h < 112; h++) issue(h, 50);

      // Contention across a full line, including the last pixel slot at 636 and hblank
      rq = 3'b111;
      sticky = 3'b111;
      for (int h = 0; h < 800; h++) issue(h, 20);
      rq = 3'b000;
      sticky = 3'b000;

      // Write in vblank, then see it on the next frame at h=22..25
      rwe = 3'b100;
      raddr[2] = 15'd5;
      rwd[2] = 8'hA5;
      rq = 3'b100;
      for (int h = 96; h < 104; h++) issue(h, 490);
      rwe = 3'b000;
      for (int h = 16; h < 32; h++) issue(h, 0);

      // Two frame boundaries
      for (int f = 0; f < 2; f++) begin
         for (int h = 796; h < 800; h++) issue(h, 479);
         for (int h = 0; h < 6; h++) issue(h, 480);
      end
      for (int h = 600; h < 606; h++) issue(h, 500);

      chk("drain_gnt", exp_g.size(), 0);
      chk("drain_rvalid", exp_r.size(), 0);
      chk("drain_fetch", exp_f.size(), 0);
      chk("drain_pix", exp_p.size(), 0);
      chk("drain_tick", exp_t.size(), 0);
      chk("tick_count", tick_cnt, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
